// File: rtl/user_flash_writer.sv
// user_flash_writer: sequences program-word / erase-row commands onto a user flash macro
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   req, op, addr, data_i  command request (op 0 = program word, 1 = erase row), word address, write data
//   busy, done, err     command in progress, one-cycle completion pulse, one-cycle rejection pulse
//   xe, ye, se, prog, erase, nvstr, xadr, yadr, din  flash macro controls, address and data
module user_flash_writer #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int T_NVS_US   = 5,
    parameter int T_PGS_US   = 10,
    parameter int T_PROG_US  = 16,
    parameter int T_NVH_US   = 5,
    parameter int T_RCV_US   = 10,
    parameter int T_ERASE_US = 100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        op,
    input  logic [14:0] addr,
    input  logic [31:0] data_i,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        xe,
    output logic        ye,
    output logic        se,
    output logic        prog,
    output logic        erase,
    output logic        nvstr,
    output logic [8:0]  xadr,
    output logic [5:0]  yadr,
    output logic [31:0] din
);
    localparam int MHZ = CLK_FREQ / 1_000_000;

    function automatic logic [23:0] cyc(input int t_us);
        int n;
        n = MHZ * t_us;
        return (n < 1) ? 24'd1 : n[23:0];
    endfunction

    // counter is loaded with N-1 on entry so each state lasts exactly N cycles
    localparam logic [23:0] L_NVS   = cyc(T_NVS_US) - 24'd1;
    localparam logic [23:0] L_PGS   = cyc(T_PGS_US) - 24'd1;
    localparam logic [23:0] L_PROG  = cyc(T_PROG_US) - 24'd1;
    localparam logic [23:0] L_NVH   = cyc(T_NVH_US) - 24'd1;
    localparam logic [23:0] L_RCV   = cyc(T_RCV_US) - 24'd1;
    localparam logic [23:0] L_ERASE = cyc(T_ERASE_US) - 24'd1;

    typedef enum logic [2:0] {IDLE, SETUP, NVS, PROG, PGH, NVH, RCV, DONE} state_t;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic        op_q;
    logic        row_ok, accept, expired;

    assign row_ok  = addr[14:6] < 9'd304;
    assign accept  = (state == IDLE) && req && row_ok;
    assign expired = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 1'b0;
            xadr  <= '0;
            yadr  <= '0;
            din   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= (state == IDLE) && req && !row_ok;
            if (accept) begin
                op_q <= op;
                xadr <= addr[14:6];
                yadr <= addr[5:0];
                din  <= data_i;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = expired ? '0 : cnt - 24'd1;
        case (state)
            IDLE: if (accept) begin
                state_n = SETUP;
                cnt_n   = L_NVS;
            end
            SETUP: if (expired) begin
                state_n = NVS;
                cnt_n   = op_q ? L_ERASE : L_PGS;
            end
            NVS: if (expired) begin
                state_n = op_q ? NVH : PROG;
                cnt_n   = op_q ? L_NVH : L_PROG;
            end
            PROG: if (expired) begin
                state_n = PGH;
                cnt_n   = '0;
            end
            PGH: begin
                state_n = NVH;
                cnt_n   = L_NVH;
            end
            NVH: if (expired) begin
                state_n = RCV;
                cnt_n   = L_RCV;
            end
            RCV: if (expired) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy  = (state != IDLE) && (state != DONE);
    assign xe    = busy;
    assign done  = (state == DONE);
    assign se    = 1'b0;
    assign ye    = (state == PROG);
    assign nvstr = (state == NVS) || (state == PROG) || (state == PGH) || (state == NVH);
    assign prog  = !op_q && ((state == SETUP) || (state == NVS) || (state == PROG) || (state == PGH));
    assign erase = op_q && ((state == SETUP) || (state == NVS));
endmodule
